// File: rtl/m_cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes, SR/Cause field positions.
package m_cp0_pkg;

   // CP0 register numbers
   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   // Exception codes (0 on the pipeline means "no exception")
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // SR field positions
   localparam int SR_IE    = 0;
   localparam int SR_EXL   = 1;
   localparam int SR_IM_LO = 10;
   localparam int SR_IM_HI = 15;

   // Cause field positions
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_BD     = 31;

endpackage

// File: rtl/m_cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRID, exception and interrupt request generation.
module m_cp0
   import m_cp0_pkg::*;
#(
   parameter logic [31:0] PRID = 32'h0000_2022
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        Req,
   output logic [31:0] DOut,
   output logic [31:0] EPCOut
);

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   // Request generation; gated by reset so nothing escapes while held in reset
   always_comb begin
      int_req = (|(HWInt & im)) & ie & ~exl;
      exc_req = (ExcCodeIn != EXC_INT) & ~exl;
      Req     = (int_req | exc_req) & reset;
   end

   // Assemble architectural views of SR and Cause; unimplemented bits read 0
   always_comb begin
      sr_val                       = '0;
      sr_val[SR_IM_HI:SR_IM_LO]    = im;
      sr_val[SR_EXL]               = exl;
      sr_val[SR_IE]                = ie;
      cause_val                            = '0;
      cause_val[CAUSE_BD]                  = bd;
      cause_val[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
      cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
   end

   // mfc0 read mux; reads the registered state only, no same-cycle forwarding
   always_comb begin
      unique case (A1)
         CP0_SR:    DOut = sr_val;
         CP0_CAUSE: DOut = cause_val;
         CP0_EPC:   DOut = epc;
         CP0_PRID:  DOut = PRID;
         default:   DOut = '0;
      endcase
      EPCOut = epc;
   end

   // State update: exception entry beats mtc0 and eret; IP samples HWInt every edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip <= HWInt;
         if (Req) begin
            exl      <= 1'b1;
            bd       <= BDIn;
            exc_code <= int_req ? EXC_INT : ExcCodeIn;
            epc      <= BDIn ? (VPC - 32'd4) : VPC;
         end else begin
            if (WE && A2 == CP0_SR) begin
               im  <= DIn[SR_IM_HI:SR_IM_LO];
               exl <= DIn[SR_EXL];
               ie  <= DIn[SR_IE];
            end
            if (WE && A2 == CP0_EPC)
               epc <= DIn;
            // eret leaving the handler takes precedence over a same-cycle SR write of EXL
            if (EXLClr)
               exl <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_m_cp0.sv
// Directed self-checking bench for m_cp0.
module tb_m_cp0;

   localparam logic [31:0] PRID = 32'h0000_2022;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  A1, A2;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic        Req;
   logic [31:0] DOut;
   logic [31:0] EPCOut;

   int checks = 0;
   int failures = 0;

   m_cp0 #(.PRID(PRID)) dut (
      .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
      .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
      .EXLClr(EXLClr), .Req(Req), .DOut(DOut), .EPCOut(EPCOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Read a CP0 register combinationally and compare
   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      A1 = a;
      #1;
      chk(tag, DOut, exp);
   endtask

   task automatic idle();
      A2 = 5'd0; DIn = '0; WE = 1'b0; VPC = '0; BDIn = 1'b0;
      ExcCodeIn = 5'd0; HWInt = '0; EXLClr = 1'b0;
   endtask

   // Advance one edge; inputs are driven 1 time unit after it
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      A1 = 5'd0;
      idle();
      reset = 1'b0;
      ExcCodeIn = 5'd12;
      #2;
      chk("rst_req", {31'b0, Req}, 32'd0);
      rd("rst_sr", 5'd12, 32'd0);
      rd("rst_cause", 5'd13, 32'd0);
      rd("rst_epc", 5'd14, 32'd0);
      rd("rst_prid", 5'd15, PRID);
      rd("rst_other", 5'd3, 32'd0);
      chk("rst_epcout", EPCOut, 32'd0);
      cyc();
      reset = 1'b1;
      idle();
      cyc();

      // Overflow exception
      ExcCodeIn = 5'd12; VPC = 32'h0000_3010;
      #1 chk("ov_req", {31'b0, Req}, 32'd1);
      cyc(); idle();
      chk("ov_epc", EPCOut, 32'h0000_3010);
      rd("ov_cause", 5'd13, 32'h0000_0030);
      rd("ov_sr", 5'd12, 32'h0000_0002);

      // No nesting while EXL=1
      ExcCodeIn = 5'd12; VPC = 32'h0000_5000;
      #1 chk("exl_block_req", {31'b0, Req}, 32'd0);
      cyc(); idle();
      chk("exl_block_epc", EPCOut, 32'h0000_3010);
      EXLClr = 1'b1;
      cyc(); idle();
      rd("eret_sr", 5'd12, 32'd0);

      // Delay-slot exception
      BDIn = 1'b1; VPC = 32'h0000_3008; ExcCodeIn = 5'd10;
      #1 chk("bd_req", {31'b0, Req}, 32'd1);
      cyc(); idle();
      chk("bd_epc", EPCOut, 32'h0000_3004);
      rd("bd_cause", 5'd13, 32'h8000_0028);
      EXLClr = 1'b1;
      cyc(); idle();

      // mtc0 SR, not forwarded same cycle
      WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
      rd("sr_nofwd", 5'd12, 32'd0);
      cyc(); idle();
      rd("sr_wr", 5'd12, 32'h0000_0401);

      // Interrupt beats a simultaneous exception
      HWInt = 6'b000001; ExcCodeIn = 5'd4; VPC = 32'h0000_3100;
      #1 chk("int_req", {31'b0, Req}, 32'd1);
      cyc(); idle();
      HWInt = 6'b000001;
      rd("int_cause", 5'd13, 32'h0000_0400);
      chk("int_epc", EPCOut, 32'h0000_3100);
      rd("int_sr", 5'd12, 32'h0000_0403);
      HWInt = '0; EXLClr = 1'b1;
      cyc(); idle();
      rd("int_eret_sr", 5'd12, 32'h0000_0401);

      // Masking: IE=0 with all IM set, then IM=0 with IE=1
      WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC00;
      cyc(); idle();
      HWInt = 6'h3F;
      #1 chk("mask_ie_req", {31'b0, Req}, 32'd0);
      cyc(); idle();
      WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0001;
      cyc(); idle();
      HWInt = 6'h3F;
      #1 chk("mask_im_req", {31'b0, Req}, 32'd0);
      cyc(); idle();

      // Writes to Cause are ignored
      WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
      cyc(); idle();
      rd("cause_ro", 5'd13, 32'd0);

      // Collision: exception suppresses a same-cycle mtc0 EPC
      WE = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEC; ExcCodeIn = 5'd12; VPC = 32'h0000_3000;
      #1 chk("col_req", {31'b0, Req}, 32'd1);
      cyc(); idle();
      chk("col_epc", EPCOut, 32'h0000_3000);
      rd("col_sr", 5'd12, 32'h0000_0003);
      EXLClr = 1'b1;
      cyc(); idle();
      rd("col_eret_sr", 5'd12, 32'h0000_0001);

      // Req and EXLClr together: EXL stays set
      ExcCodeIn = 5'd5; VPC = 32'h0000_3200; EXLClr = 1'b1;
      cyc(); idle();
      rd("req_vs_clr_sr", 5'd12, 32'h0000_0003);
      rd("req_vs_clr_cause", 5'd13, 32'h0000_0014);

      // Async reset mid-cycle while EXL=1
      #2 reset = 1'b0;
      rd("arst_sr", 5'd12, 32'd0);
      rd("arst_cause", 5'd13, 32'd0);
      rd("arst_epc", 5'd14, 32'd0);
      rd("arst_prid", 5'd15, PRID);
      chk("arst_epcout", EPCOut, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // First edge after reset release performs a normal update
      WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_1234;
      cyc(); idle();
      chk("post_rst_epc", EPCOut, 32'h0000_1234);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
